// File: rtl/uart_seg_display_driver.sv
// ==== uart_seg_display_driver: UART chars -> 4-digit 7-segment drive with anode2 prefetch (rev 1.0) ====
`default_nettype none

module uart_seg_display_driver #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  input  logic [3:0] anode,
  input  logic [3:0] anode2,
  output logic [3:0] an_out,
  output logic [6:0] seg,
  output logic       sync_err
);

  localparam logic [4:0] CODE_DASH  = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] STROBE_IDLE = 4'b1111;

  logic [4:0] digit_buf [4];
  logic [4:0] sel_code;
  logic [1:0] sel_idx;
  logic       sel_valid;
  logic [6:0] seg_next;

  logic       a_hot;
  logic [1:0] a_idx;
  logic       a2_hot;
  logic [1:0] a2_idx;
  logic       a_bad;
  logic       a2_bad;
  logic       consume;
  logic       fault;

  function automatic logic [4:0] map_char(input logic [7:0] c);
    logic [4:0] code;
    code = CODE_DASH;
    if (c >= 8'h30 && c <= 8'h39)
      code = {1'b0, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      code = {1'b0, c[3:0]} + 5'd9;
    return code;
  endfunction

  // Segment patterns are held internally active-low; polarity is applied at the pins.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:      s = 7'b0000001;
      5'd1:      s = 7'b1001111;
      5'd2:      s = 7'b0010010;
      5'd3:      s = 7'b0000110;
      5'd4:      s = 7'b1001100;
      5'd5:      s = 7'b0100100;
      5'd6:      s = 7'b0100000;
      5'd7:      s = 7'b0001111;
      5'd8:      s = 7'b0000000;
      5'd9:      s = 7'b0000100;
      5'd10:     s = 7'b0001000;
      5'd11:     s = 7'b1100000;
      5'd12:     s = 7'b0110001;
      5'd13:     s = 7'b1000010;
      5'd14:     s = 7'b0110000;
      5'd15:     s = 7'b0111000;
      CODE_DASH: s = 7'b1111110;
      default:   s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Returns {one_hot_low, digit_index}.
  function automatic logic [2:0] strobe_dec(input logic [3:0] s);
    logic [2:0] r;
    case (s)
      4'b0111: r = 3'b100;
      4'b1011: r = 3'b101;
      4'b1101: r = 3'b110;
      4'b1110: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] drive(input logic [6:0] v);
    return SEG_ACTIVE_LOW ? v : ~v;
  endfunction

  assign {a_hot, a_idx}   = strobe_dec(anode);
  assign {a2_hot, a2_idx} = strobe_dec(anode2);
  assign a_bad   = (anode  != STROBE_IDLE) && !a_hot;
  assign a2_bad  = (anode2 != STROBE_IDLE) && !a2_hot;
  assign consume = a_hot && sel_valid && (a_idx == sel_idx);
  // A new prefetch is only an overwrite if the old selection is not being consumed this cycle.
  assign fault   = (a_hot && !consume) || a_bad || a2_bad || (a2_hot && sel_valid && !consume);

  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digit_buf[i] <= CODE_BLANK;
    end else if (rx_valid) begin
      if (rx_error) begin
        for (int i = 0; i < 4; i++) digit_buf[i] <= CODE_DASH;
      end else begin
        digit_buf[0] <= digit_buf[1];
        digit_buf[1] <= digit_buf[2];
        digit_buf[2] <= digit_buf[3];
        digit_buf[3] <= map_char(rx_data);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      sel_code  <= CODE_BLANK;
      sel_idx   <= 2'd0;
      sel_valid <= 1'b0;
      seg_next  <= SEG_BLANK;
    end else begin
      if (a2_hot) begin
        sel_code  <= digit_buf[a2_idx];
        sel_idx   <= a2_idx;
        sel_valid <= 1'b1;
      end else if (consume) begin
        sel_valid <= 1'b0;
      end
      seg_next <= decode(sel_code);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      an_out   <= STROBE_IDLE;
      seg      <= drive(SEG_BLANK);
      sync_err <= 1'b0;
    end else begin
      if (a_hot) begin
        an_out <= anode;
        seg    <= consume ? drive(seg_next) : drive(SEG_BLANK);
      end else begin
        an_out <= STROBE_IDLE;
        seg    <= drive(SEG_BLANK);
      end
      if (fault) sync_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_seg_display_driver.sv
// ==== tb_uart_seg_display_driver: directed vectors for uart_seg_display_driver (rev 1.0) ====
`default_nettype none

module tb_uart_seg_display_driver;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SA = 7'b0001000, SBB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001, SDD = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000;
  localparam logic [6:0] SD = 7'b1111110, SB = 7'b1111111;

  logic       Clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [3:0] anode;
  logic [3:0] anode2;
  logic [3:0] an_out;
  logic [6:0] seg;
  logic       sync_err;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_seg_display_driver dut (
    .Clk      (Clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .anode    (anode),
    .anode2   (anode2),
    .an_out   (an_out),
    .seg      (seg),
    .sync_err (sync_err)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        err;
    logic [27:0] exp;   // {digit0, digit1, digit2, digit3}
  } vec_t;

  vec_t vecs [25];

  function automatic logic [3:0] strobe(input int k);
    logic [3:0] one;
    one = 4'b1000;
    return ~(one >> k);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    anode = 4'hF; anode2 = 4'hF; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic v, input logic e);
    idle_inputs();
    rx_data = d; rx_valid = v; rx_error = e;
    tick();
    idle_inputs();
  endtask

  // One 16-cycle round: anode2 for digit k at cycle 4k, anode at 4k+2, output checked after that edge.
  task automatic run_round(input string tag, input logic [27:0] exp, input logic [3:0] skip,
                           input int rx_cyc, input logic [7:0] rx_byte);
    for (int c = 0; c < 16; c++) begin
      int k;
      k = c / 4;
      anode2   = (c % 4 == 0 && !skip[k]) ? strobe(k) : 4'hF;
      anode    = (c % 4 == 2) ? strobe(k) : 4'hF;
      rx_valid = (c == rx_cyc);
      rx_error = 1'b0;
      rx_data  = rx_byte;
      tick();
      if (c % 4 == 2)
        chk($sformatf("%s digit%0d", tag, k), {5'd0, an_out, seg}, {5'd0, strobe(k), exp[27-7*k -: 7]});
      else
        chk($sformatf("%s idle c%0d", tag, c), {5'd0, an_out, seg}, {5'd0, 4'hF, SB});
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h31, 1'b1, 1'b0, {SB, SB, SB, S1}};
    vecs[1]  = '{8'h32, 1'b1, 1'b0, {SB, SB, S1, S2}};
    vecs[2]  = '{8'h41, 1'b1, 1'b0, {SB, S1, S2, SA}};
    vecs[3]  = '{8'h66, 1'b1, 1'b0, {S1, S2, SA, SF}};
    vecs[4]  = '{8'h5A, 1'b1, 1'b0, {S2, SA, SF, SD}};
    vecs[5]  = '{8'h99, 1'b1, 1'b1, {SD, SD, SD, SD}};
    vecs[6]  = '{8'h39, 1'b1, 1'b0, {SD, SD, SD, S9}};
    vecs[7]  = '{8'h65, 1'b1, 1'b0, {SD, SD, S9, SE}};
    vecs[8]  = '{8'h63, 1'b1, 1'b0, {SD, S9, SE, SC}};
    vecs[9]  = '{8'h30, 1'b1, 1'b0, {S9, SE, SC, S0}};
    vecs[10] = '{8'h47, 1'b1, 1'b0, {SE, SC, S0, SD}};
    vecs[11] = '{8'h64, 1'b1, 1'b0, {SC, S0, SD, SDD}};
    vecs[12] = '{8'h62, 1'b1, 1'b0, {S0, SD, SDD, SBB}};
    vecs[13] = '{8'h33, 1'b0, 1'b1, {S0, SD, SDD, SBB}};
    vecs[14] = '{8'h38, 1'b1, 1'b0, {SD, SDD, SBB, S8}};
    vecs[15] = '{8'h37, 1'b1, 1'b0, {SDD, SBB, S8, S7}};
    vecs[16] = '{8'h34, 1'b1, 1'b0, {SBB, S8, S7, S4}};
    vecs[17] = '{8'h35, 1'b1, 1'b0, {S8, S7, S4, S5}};
    vecs[18] = '{8'h36, 1'b1, 1'b0, {S7, S4, S5, S6}};
    vecs[19] = '{8'h2F, 1'b1, 1'b0, {S4, S5, S6, SD}};
    vecs[20] = '{8'h3A, 1'b1, 1'b0, {S5, S6, SD, SD}};
    vecs[21] = '{8'h40, 1'b1, 1'b0, {S6, SD, SD, SD}};
    vecs[22] = '{8'h61, 1'b1, 1'b0, {SD, SD, SD, SA}};
    vecs[23] = '{8'h46, 1'b1, 1'b0, {SD, SD, SA, SF}};
    vecs[24] = '{8'h33, 1'b1, 1'b0, {SD, SA, SF, S3}};

    do_reset();
    chk("reset an_out", {12'd0, an_out}, {12'd0, 4'hF});
    chk("reset seg", {9'd0, seg}, {9'd0, SB});
    chk("reset sync_err", {15'd0, sync_err}, 16'd0);
    repeat (3) tick();
    chk("idle seg", {5'd0, an_out, seg}, {5'd0, 4'hF, SB});

    run_round("blank round", {SB, SB, SB, SB}, 4'b0000, -1, 8'h00);
    chk("blank sync_err", {15'd0, sync_err}, 16'd0);

    for (int i = 0; i < 25; i++) begin
      send(vecs[i].data, vecs[i].valid, vecs[i].err);
      run_round($sformatf("vec%0d", i), vecs[i].exp, 4'b0000, -1, 8'h00);
      chk($sformatf("vec%0d sync_err", i), {15'd0, sync_err}, 16'd0);
    end

    // Capture coinciding with the digit-3 prefetch: old value shows this round.
    send(8'h32, 1'b1, 1'b0);
    run_round("pre same-cycle", {SA, SF, S3, S2}, 4'b0000, -1, 8'h00);
    run_round("same-cycle", {SA, SF, S3, S2}, 4'b0000, 12, 8'h37);
    run_round("after same-cycle", {SF, S3, S2, S7}, 4'b0000, -1, 8'h00);
    chk("same-cycle sync_err", {15'd0, sync_err}, 16'd0);

    run_round("drop digit1", {SF, SB, S2, S7}, 4'b0010, -1, 8'h00);
    chk("drop sync_err", {15'd0, sync_err}, 16'd1);
    run_round("after drop", {SF, S3, S2, S7}, 4'b0000, -1, 8'h00);
    chk("sticky sync_err", {15'd0, sync_err}, 16'd1);

    do_reset();
    chk("reset clears sync_err", {15'd0, sync_err}, 16'd0);
    anode = 4'b0011;
    tick();
    idle_inputs();
    chk("bad anode out", {5'd0, an_out, seg}, {5'd0, 4'hF, SB});
    chk("bad anode sync_err", {15'd0, sync_err}, 16'd1);

    do_reset();
    anode2 = 4'b0000;
    tick();
    idle_inputs();
    chk("bad anode2 sync_err", {15'd0, sync_err}, 16'd1);

    do_reset();
    anode2 = strobe(0);
    tick();
    anode2 = strobe(1);
    tick();
    idle_inputs();
    chk("overwrite sync_err", {15'd0, sync_err}, 16'd1);

    // Reset landing on the anode edge discards the pending selection.
    do_reset();
    send(8'h38, 1'b1, 1'b0);
    anode2 = strobe(3);
    tick();
    idle_inputs();
    tick();
    anode = strobe(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    chk("mid reset out", {5'd0, an_out, seg}, {5'd0, 4'hF, SB});
    chk("mid reset sync_err", {15'd0, sync_err}, 16'd0);
    tick();
    anode = strobe(3);
    tick();
    idle_inputs();
    chk("orphan anode out", {5'd0, an_out, seg}, {5'd0, 4'b1110, SB});
    chk("orphan anode sync_err", {15'd0, sync_err}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
